// File: rtl/pacman_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pacman_pkg                                                         |
// | Shared grid geometry, colours and direction codes for pacman.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pacman_pkg;

  localparam int TILE   = 5;
  localparam int GRID_W = 27;
  localparam int GRID_H = 24;

  localparam logic [2:0] PAC_COLOUR = 3'b110;
  localparam logic [2:0] BG_COLOUR  = 3'b000;

  typedef enum logic [2:0] {
    DIR_RIGHT = 3'd0,
    DIR_UP    = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_WAIT  = 3'd4
  } dir_e;

  function automatic logic [7:0] pixel_x(input logic [7:0] tx, input logic [2:0] px);
    return tx * 8'(TILE) + {5'd0, px};
  endfunction

  function automatic logic [6:0] pixel_y(input logic [6:0] ty, input logic [2:0] py);
    return ty * 7'(TILE) + {4'd0, py};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_sprite_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pacman_sprite_rom                                                  |
// | Combinational 5x5 sprite lookup: (dir, px, py) -> pixel bit.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pacman_sprite_rom
  import pacman_pkg::*;
(
  input  logic [2:0] i_dir,
  input  logic [2:0] i_px,
  input  logic [2:0] i_py,
  output logic       o_bit
);

  logic [24:0] w_rows;
  logic [4:0]  w_idx;
  logic        w_in_tile;

  // Rows are packed py0 first, and within a row px0 is the leftmost character.
  always_comb begin
    w_rows = 25'b01110_11111_11111_11111_01110;
    case (i_dir)
      DIR_RIGHT: w_rows = 25'b01110_11110_11100_11110_01110;
      DIR_UP:    w_rows = 25'b10001_11011_11111_11111_01110;
      DIR_LEFT:  w_rows = 25'b01110_01111_00111_01111_01110;
      DIR_DOWN:  w_rows = 25'b01110_11111_11111_11011_10001;
      DIR_WAIT:  w_rows = 25'b01110_11111_11111_11111_01110;
      default:   w_rows = 25'b01110_11111_11111_11111_01110;
    endcase
  end

  assign w_in_tile = (i_px < 3'd5) && (i_py < 3'd5);
  assign w_idx     = 5'd24 - (5'(i_py) * 5'd5 + 5'(i_px));
  assign o_bit     = w_in_tile ? w_rows[w_idx] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/pacman_tile_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pacman_tile_drawer                                                 |
// | Erases the previous pacman tile, then draws the new 5x5 sprite.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pacman_tile_drawer
  import pacman_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic [7:0] i_tile_x,
  input  logic [6:0] i_tile_y,
  input  logic [2:0] i_dir,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_plot,
  output logic [7:0] o_vga_x,
  output logic [6:0] o_vga_y,
  output logic [2:0] o_colour
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;

  logic [1:0] r_state, w_state;
  logic [2:0] r_px, r_py, w_px, w_py;
  logic [7:0] r_new_tx, w_new_tx, r_old_tx;
  logic [6:0] r_new_ty, w_new_ty, r_old_ty;
  logic [2:0] r_dir, w_dir;
  logic       r_prev_valid;

  logic       r_busy, r_done, r_err, r_plot;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_colour;

  logic       w_in_range, w_accept, w_reject, w_moved, w_last;
  logic       w_sprite_bit;
  logic [7:0] w_pix_tx;
  logic [6:0] w_pix_ty;
  logic [2:0] w_colour;

  assign w_in_range = (i_tile_x < 8'(GRID_W)) && (i_tile_y < 7'(GRID_H));
  assign w_accept   = (r_state == S_IDLE) && i_start && w_in_range;
  assign w_reject   = (r_state == S_IDLE) && i_start && !w_in_range;
  assign w_moved    = (i_tile_x != r_old_tx) || (i_tile_y != r_old_ty);
  assign w_last     = (r_px == 3'd4) && (r_py == 3'd4);

  // Next-state values describe the pixel that will be on the outputs after the edge.
  always_comb begin
    w_state  = r_state;
    w_px     = r_px;
    w_py     = r_py;
    w_new_tx = r_new_tx;
    w_new_ty = r_new_ty;
    w_dir    = r_dir;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_new_tx = i_tile_x;
          w_new_ty = i_tile_y;
          w_dir    = i_dir;
          w_px     = 3'd0;
          w_py     = 3'd0;
          w_state  = (r_prev_valid && w_moved) ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW: begin
        if (w_last) begin
          w_px    = 3'd0;
          w_py    = 3'd0;
          w_state = (r_state == S_ERASE) ? S_DRAW : S_IDLE;
        end else if (r_px == 3'd4) begin
          w_px = 3'd0;
          w_py = r_py + 3'd1;
        end else begin
          w_px = r_px + 3'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  pacman_sprite_rom u_rom (
    .i_dir (w_dir),
    .i_px  (w_px),
    .i_py  (w_py),
    .o_bit (w_sprite_bit)
  );

  assign w_pix_tx = (w_state == S_ERASE) ? r_old_tx : w_new_tx;
  assign w_pix_ty = (w_state == S_ERASE) ? r_old_ty : w_new_ty;
  assign w_colour = ((w_state == S_DRAW) && w_sprite_bit) ? PAC_COLOUR : BG_COLOUR;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_px         <= 3'd0;
      r_py         <= 3'd0;
      r_new_tx     <= 8'd0;
      r_new_ty     <= 7'd0;
      r_old_tx     <= 8'd0;
      r_old_ty     <= 7'd0;
      r_dir        <= 3'd0;
      r_prev_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_plot       <= 1'b0;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_colour     <= 3'd0;
    end else begin
      r_state  <= w_state;
      r_px     <= w_px;
      r_py     <= w_py;
      r_new_tx <= w_new_tx;
      r_new_ty <= w_new_ty;
      r_dir    <= w_dir;
      r_err    <= w_reject;
      r_done   <= (r_state == S_DRAW) && w_last;
      r_plot   <= (w_state != S_IDLE);
      r_busy   <= (w_state != S_IDLE);
      if ((r_state == S_DRAW) && w_last) begin
        r_old_tx     <= r_new_tx;
        r_old_ty     <= r_new_ty;
        r_prev_valid <= 1'b1;
      end
      if (w_state != S_IDLE) begin
        r_vga_x  <= pixel_x(w_pix_tx, w_px);
        r_vga_y  <= pixel_y(w_pix_ty, w_py);
        r_colour <= w_colour;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_plot   = r_plot;
  assign o_vga_x  = r_vga_x;
  assign o_vga_y  = r_vga_y;
  assign o_colour = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_pacman_tile_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pacman_tile_drawer                                              |
// | Table-driven bench for the pacman erase/draw pixel sequencer.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pacman_tile_drawer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_tile_x = 8'd0;
  logic [6:0] i_tile_y = 7'd0;
  logic [2:0] i_dir = 3'd0;
  logic       o_busy, o_done, o_err, o_plot;
  logic [7:0] o_vga_x;
  logic [6:0] o_vga_y;
  logic [2:0] o_colour;

  int n_cmp = 0;
  int n_bad = 0;
  bit chained = 1'b0;

  always #5 clock = ~clock;

  pacman_tile_drawer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_start  (i_start),
    .i_tile_x (i_tile_x),
    .i_tile_y (i_tile_y),
    .i_dir    (i_dir),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_plot   (o_plot),
    .o_vga_x  (o_vga_x),
    .o_vga_y  (o_vga_y),
    .o_colour (o_colour)
  );

  typedef struct {
    logic [7:0] tx;
    logic [6:0] ty;
    logic [2:0] dir;
    bit         is_err;
    bit         erase;
    logic [7:0] ox;
    logic [6:0] oy;
    int         inject;
    bit         chain;
    logic [7:0] prx;
    logic [6:0] pry;
    logic [2:0] pcol;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input int tx, input int ty, input int dir, input bit is_err,
                              input bit erase, input int ox, input int oy, input int inject,
                              input bit chain, input int prx, input int pry, input int pcol);
    vec_t v;
    v.tx = 8'(tx); v.ty = 7'(ty); v.dir = 3'(dir);
    v.is_err = is_err; v.erase = erase;
    v.ox = 8'(ox); v.oy = 7'(oy);
    v.inject = inject; v.chain = chain;
    v.prx = 8'(prx); v.pry = 7'(pry); v.pcol = 3'(pcol);
    return v;
  endfunction

  // Hand-transcribed sprite table: py0 row first, px0 leftmost.
  function automatic bit spr(input logic [2:0] d, input int px, input int py);
    logic [24:0] rows;
    case (d)
      3'd0:    rows = 25'b01110_11110_11100_11110_01110;
      3'd1:    rows = 25'b10001_11011_11111_11111_01110;
      3'd2:    rows = 25'b01110_01111_00111_01111_01110;
      3'd3:    rows = 25'b01110_11111_11111_11011_10001;
      default: rows = 25'b01110_11111_11111_11111_01110;
    endcase
    return rows[24 - 5 * py - px];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic [7:0] tx, input logic [6:0] ty, input logic [2:0] d);
    i_start  = 1'b1;
    i_tile_x = tx;
    i_tile_y = ty;
    i_dir    = d;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  nplots, j, jj, ex, ey;
    logic [2:0] ec;
    bit  probe_hit;
    if (!chained) drive_start(v.tx, v.ty, v.dir);
    chained   = 1'b0;
    probe_hit = 1'b0;
    nplots    = v.is_err ? 0 : (v.erase ? 50 : 25);
    for (int k = 1; k <= nplots + 1; k++) begin
      @(negedge clock);
      i_start = 1'b0;
      if (v.is_err) begin
        check($sformatf("v%0d_err_pulse", idx), {o_plot, o_busy, o_done, o_err}, 4'b0001);
        @(negedge clock);
        check($sformatf("v%0d_err_quiet", idx), {o_plot, o_busy, o_done, o_err}, 4'b0000);
      end else if (k <= nplots) begin
        j = k - 1;
        if (v.erase && j < 25) begin
          ex = int'(v.ox) * 5 + j % 5;
          ey = int'(v.oy) * 5 + j / 5;
          ec = 3'b000;
        end else begin
          jj = v.erase ? j - 25 : j;
          ex = int'(v.tx) * 5 + jj % 5;
          ey = int'(v.ty) * 5 + jj / 5;
          ec = spr(v.dir, jj % 5, jj / 5) ? 3'b110 : 3'b000;
        end
        check($sformatf("v%0d_pix%0d", idx, j),
              {o_plot, o_busy, o_done, o_err, o_vga_x, o_vga_y, o_colour},
              {4'b1100, 8'(ex), 7'(ey), ec});
        if (k > nplots - 25 && o_vga_x == v.prx && o_vga_y == v.pry) begin
          probe_hit = 1'b1;
          check($sformatf("v%0d_probe", idx), o_colour, v.pcol);
        end
      end else begin
        check($sformatf("v%0d_done", idx), {o_plot, o_busy, o_done, o_err}, 4'b0010);
        if (v.chain) begin
          drive_start(vecs[idx + 1].tx, vecs[idx + 1].ty, vecs[idx + 1].dir);
          chained = 1'b1;
        end
      end
      if (k == v.inject) drive_start(8'd20, 7'd20, 3'd4);
    end
    if (!v.is_err) check($sformatf("v%0d_probe_seen", idx), 32'(probe_hit), 32'd1);
  endtask

  initial begin
    vec_t rv;
    //           tx  ty dir err ers ox  oy  inj chn prx  pry  col
    vecs[0] = mk( 0,  0, 0, 0, 0,  0,  0,  0, 0,   4,   2, 3'b000);
    vecs[1] = mk(26, 23, 1, 0, 1,  0,  0,  0, 0, 130, 115, 3'b110);
    vecs[2] = mk(26, 23, 2, 0, 0,  0,  0,  0, 0, 130, 117, 3'b000);
    vecs[3] = mk(27,  0, 0, 1, 0,  0,  0,  0, 0,   0,   0, 3'b000);
    vecs[4] = mk( 0, 24, 3, 1, 0,  0,  0,  0, 0,   0,   0, 3'b000);
    vecs[5] = mk( 3,  4, 4, 0, 1, 26, 23,  0, 1,  16,  21, 3'b110);
    vecs[6] = mk(10, 10, 3, 0, 1,  3,  4,  0, 0,  54,  54, 3'b110);
    vecs[7] = mk(10, 10, 7, 0, 0,  0,  0, 12, 0,  50,  50, 3'b000);
    vecs[8] = mk( 1,  1, 0, 0, 1, 10, 10, 40, 0,   5,   7, 3'b110);

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", {o_plot, o_busy, o_done, o_err, o_vga_x, o_vga_y, o_colour}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
      if (!chained) repeat (2) @(negedge clock);
    end

    // Abort an erase of (1,1) part-way through with reset.
    drive_start(8'd2, 7'd2, 3'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      i_start = 1'b0;
      check($sformatf("pre_reset_%0d", k), {o_plot, o_busy, o_vga_y}, {2'b11, 7'(5 + (k - 1) / 5)});
    end
    reset_n = 1'b0;
    @(negedge clock);
    check("reset_abort", {o_plot, o_busy, o_done, o_err}, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_idle", {o_plot, o_busy}, 2'b00);
    rv = mk(5, 5, 0, 0, 0, 0, 0, 0, 0, 25, 27, 3'b110);
    run_vec(9, rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
